// File: rtl/ram8_if.sv
// Bus bundle for the ram8 memory primitive: write data, load strobe,
// shared read/write address and combinational read data.
interface ram8_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic [2:0]       address;
    logic [WIDTH-1:0] out;

    // Requester drives write data, strobe and address; memory returns read data.
    modport master (
        output in,
        output load,
        output address,
        input  out
    );

    modport slave (
        input  in,
        input  load,
        input  address,
        output out
    );
endinterface

// File: rtl/ram8.sv
// ram8: eight WIDTH-bit words, one clocked write port and one combinational
// read port sharing a single address. Built structurally from a load
// demultiplexer, eight registers and an 8-way read mux.
//
// Interface semantics: there is no handshake. A write takes effect at the
// rising edge where load=1 and reset=0; out always shows word[address] as
// stored, so during the load cycle it shows the old contents and the new
// value appears one edge later (no bypass). Reset wins over load.

// Routes the load strobe to exactly one of eight outputs.
module dmux8way (
    input  logic       in_i,
    input  logic [2:0] sel_i,
    output logic [7:0] out_o
);
    // One-hot steering of the strobe; a low strobe drives all outputs low.
    always_comb begin
        out_o        = '0;
        out_o[sel_i] = in_i;
    end
endmodule

// Single word with synchronous clear and load enable.
module register16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: clear beats load, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (reset) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = in_i;
        end
    end

    // Storage element, updated only at the rising edge.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign out_o = data_q;
endmodule

// Selects one of eight words for the read port.
module mux8way16 #(
    parameter int WIDTH = 16
) (
    input  logic [7:0][WIDTH-1:0] in_i,
    input  logic [2:0]            sel_i,
    output logic [WIDTH-1:0]      out_o
);
    // Purely combinational read select; bit 2 of sel_i is the MSB.
    always_comb begin
        out_o = in_i[sel_i];
    end
endmodule

module ram8 #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    ram8_if.slave       bus
);
    logic [7:0]            word_load;
    logic [7:0][WIDTH-1:0] word_data;

    dmux8way u_dmux (
        .in_i  (bus.load),
        .sel_i (bus.address),
        .out_o (word_load)
    );

    for (genvar g = 0; g < 8; g++) begin : g_word
        register16 #(.WIDTH(WIDTH)) u_reg (
            .clk    (clk),
            .reset  (reset),
            .load_i (word_load[g]),
            .in_i   (bus.in),
            .out_o  (word_data[g])
        );
    end

    mux8way16 #(.WIDTH(WIDTH)) u_mux (
        .in_i  (word_data),
        .sel_i (bus.address),
        .out_o (bus.out)
    );
endmodule

// File: tb/tb_ram8.sv
// Bench for ram8: directed scenarios plus a randomized run, all checked
// against an eight-entry array model updated at each rising edge.
module tb_ram8;
    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [WIDTH-1:0] mem_m [8];

    ram8_if #(.WIDTH(WIDTH)) bus ();

    ram8 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, applying the memory rules to the model,
    // then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) mem_m[i] = '0;
        end else if (bus.load === 1'b1) begin
            mem_m[bus.address] = bus.in;
        end
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.load    = 1'b1;
        bus.in      = 16'hFFFF;
        bus.address = 3'd3;
        tick();
        reset    = 1'b0;
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            checks++;
            if (bus.out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d got=%h exp=0000", a, bus.out);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 8; i++) begin
            bus.address = 3'(i);
            bus.in      = 16'h0001 << i;
            bus.load    = 1'b1;
            tick();
        end
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.address = 3'(i);
            #1;
            exp = 16'h0001 << i;
            checks++;
            if (bus.out !== exp) begin
                errors++;
                $display("FAIL readback addr=%0d got=%h exp=%h", i, bus.out, exp);
            end
        end
    endtask

    task automatic test_write_latency();
        bus.address = 3'd5;
        bus.in      = 16'hBEEF;
        bus.load    = 1'b1;
        #1;
        checks++;
        if (bus.out !== 16'h0020) begin
            errors++;
            $display("FAIL latency_before got=%h exp=0020", bus.out);
        end
        tick();
        bus.load = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'hBEEF) begin
            errors++;
            $display("FAIL latency_after got=%h exp=beef", bus.out);
        end
    endtask

    task automatic test_load_gating();
        bus.load = 1'b0;
        bus.in   = 16'h1234;
        for (int e = 0; e < 4; e++) begin
            bus.address = 3'(e * 2 + 1);
            tick();
        end
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            checks++;
            if (bus.out !== mem_m[a]) begin
                errors++;
                $display("FAIL load_gating addr=%0d got=%h exp=%h", a, bus.out, mem_m[a]);
            end
        end
    endtask

    task automatic test_reset_priority();
        logic [WIDTH-1:0] exp;
        reset       = 1'b1;
        bus.load    = 1'b1;
        bus.address = 3'd7;
        bus.in      = 16'hA5A5;
        tick();
        reset    = 1'b0;
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            checks++;
            if (bus.out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_priority addr=%0d got=%h exp=0000", a, bus.out);
            end
        end
        bus.address = 3'd7;
        bus.load    = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            exp = (a == 7) ? 16'hA5A5 : 16'h0000;
            checks++;
            if (bus.out !== exp) begin
                errors++;
                $display("FAIL post_reset_write addr=%0d got=%h exp=%h", a, bus.out, exp);
            end
        end
    endtask

    task automatic test_isolation();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 8; i++) begin
            bus.address = 3'(i);
            bus.in      = 16'h0001 << i;
            bus.load    = 1'b1;
            tick();
        end
        bus.address = 3'd2;
        bus.in      = 16'hCAFE;
        tick();
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            exp = (a == 2) ? 16'hCAFE : (16'h0001 << a);
            checks++;
            if (bus.out !== exp) begin
                errors++;
                $display("FAIL isolation addr=%0d got=%h exp=%h", a, bus.out, exp);
            end
        end
    endtask

    task automatic test_x_address();
        bus.load    = 1'b0;
        bus.address = 3'bxxx;
        bus.in      = 16'hDEAD;
        tick();
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            checks++;
            if (bus.out !== mem_m[a]) begin
                errors++;
                $display("FAIL x_address addr=%0d got=%h exp=%h", a, bus.out, mem_m[a]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            reset       = ($urandom_range(0, 19) == 0);
            bus.load    = 1'($urandom_range(0, 1));
            bus.address = 3'($urandom_range(0, 7));
            bus.in      = 16'($urandom);
            #1;
            // Before the edge the read port must still show stored contents.
            checks++;
            if (bus.out !== mem_m[bus.address]) begin
                errors++;
                $display("FAIL random_pre n=%0d addr=%0d got=%h exp=%h",
                         n, bus.address, bus.out, mem_m[bus.address]);
            end
            tick();
        end
        reset    = 1'b0;
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            checks++;
            if (bus.out !== mem_m[a]) begin
                errors++;
                $display("FAIL random_final addr=%0d got=%h exp=%h", a, bus.out, mem_m[a]);
            end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b0;
        bus.load    = 1'b0;
        bus.in      = '0;
        bus.address = '0;
        for (int i = 0; i < 8; i++) mem_m[i] = '0;
        @(negedge clk);
        test_reset();
        test_write_readback();
        test_write_latency();
        test_load_gating();
        test_reset_priority();
        test_isolation();
        test_x_address();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
